// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller: default sizes,
// the operation encoding and the fixed-priority request decoder.
package pc_pkg;

  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_OFF_W   = 5;
  localparam int DEF_STACK_D = 4;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BRANCH,
    OP_JUMP,
    OP_CALL,
    OP_RET
  } pc_op_e;

  // Ret > Call > Jump > Branch > Up > hold; lower requests are dropped.
  function automatic pc_op_e pc_decode(input logic up, input logic branch,
                                       input logic jump, input logic call,
                                       input logic ret);
    if (ret)         return OP_RET;
    else if (call)   return OP_CALL;
    else if (jump)   return OP_JUMP;
    else if (branch) return OP_BRANCH;
    else if (up)     return OP_INC;
    else             return OP_HOLD;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO, ADDR_W bits x STACK_D entries. Push when full and
// pop when empty are ignored; only the occupancy counter is reset.
module ret_stack #(
  parameter int ADDR_W  = 7,
  parameter int STACK_D = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              din,
  output logic [ADDR_W-1:0]              top,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(STACK_D+1)-1:0]   depth
);

  localparam int DEPTH_W = $clog2(STACK_D + 1);
  localparam int PTR_W   = $clog2(STACK_D);

  logic [ADDR_W-1:0] mem [STACK_D];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Occupancy doubles as the write pointer; the top entry sits one below it.
  // When depth == STACK_D (power of two) the truncated pointer wraps to 0,
  // but no write happens then and rd_ptr still lands on the last entry.
  assign wr_ptr = depth[PTR_W-1:0];
  assign rd_ptr = wr_ptr - PTR_W'(1);

  assign full  = (depth == DEPTH_W'(STACK_D));
  assign empty = (depth == '0);
  assign top   = mem[rd_ptr];

  // Occupancy counter with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst)                depth <= '0;
    else if (push && !full) depth <= depth + DEPTH_W'(1);
    else if (pop && !empty) depth <= depth - DEPTH_W'(1);
  end

  // Entry storage written on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage array is deliberately left without reset; depth == 0
    // already marks every entry invalid, and this keeps it mappable to RAM.
    if (push && !full) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: increment, relative branch, absolute jump and
// call/return through ret_stack, with a sticky Fault flag.
// Optional build macro PC_SATURATE_EN: increment (and the Call push value)
// holds at the all-ones address instead of wrapping to 0.
import pc_pkg::*;

module pc_ctrl #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int OFF_W   = DEF_OFF_W,
  parameter int STACK_D = DEF_STACK_D
) (
  input  logic                          Clk,
  input  logic                          Clr,
  input  logic                          Up,
  input  logic                          Branch,
  input  logic [OFF_W-1:0]              Offset,
  input  logic                          Jump,
  input  logic                          Call,
  input  logic                          Ret,
  input  logic [ADDR_W-1:0]             Target,
  output logic [ADDR_W-1:0]             Addr,
  output logic                          StackFull,
  output logic                          StackEmpty,
  output logic [$clog2(STACK_D+1)-1:0]  Depth,
  output logic                          Fault
);

  pc_op_e            op;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] addr_br;
  logic [ADDR_W-1:0] stk_top;
  logic [ADDR_W-1:0] addr_nxt;
  logic              fault_set;

  assign op      = pc_decode(Up, Branch, Jump, Call, Ret);
  assign off_ext = ADDR_W'(signed'(Offset));
  assign addr_br = Addr + off_ext;

  // Successor address, shared by Up and by the Call return value.
  always_comb begin
`ifdef PC_SATURATE_EN
    addr_inc = (Addr == '1) ? Addr : Addr + ADDR_W'(1);
`else
    addr_inc = Addr + ADDR_W'(1);
`endif
  end

  ret_stack #(
    .ADDR_W  (ADDR_W),
    .STACK_D (STACK_D)
  ) u_stack (
    .clk   (Clk),
    .rst   (Clr),
    .push  (op == OP_CALL),
    .pop   (op == OP_RET),
    .din   (addr_inc),
    .top   (stk_top),
    .full  (StackFull),
    .empty (StackEmpty),
    .depth (Depth)
  );

  // Next-address select and fault detection for the decoded operation.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    addr_nxt  = Addr;
    fault_set = 1'b0;
    case (op)
      OP_INC:    addr_nxt = addr_inc;
      OP_BRANCH: addr_nxt = addr_br;
      OP_JUMP:   addr_nxt = Target;
      OP_CALL:   if (!StackFull)  addr_nxt = Target; else fault_set = 1'b1;
      OP_RET:    if (!StackEmpty) addr_nxt = stk_top; else fault_set = 1'b1;
      default:   ;
    endcase
  end

  // Address register and sticky fault flag; Clr overrides every request.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      Addr  <= '0;
      Fault <= 1'b0;
    end else begin
      Addr <= addr_nxt;
      if (fault_set) Fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios followed by random
// requests, all compared against a queue-based reference model.
module tb_pc_ctrl;

  localparam int ADDR_W  = 7;
  localparam int OFF_W   = 5;
  localparam int STACK_D = 4;
  localparam int DW      = $clog2(STACK_D + 1);
  localparam int A       = 1 << ADDR_W;

  logic              Clk, Clr, Up, Branch, Jump, Call, Ret;
  logic [OFF_W-1:0]  Offset;
  logic [ADDR_W-1:0] Target;
  logic [ADDR_W-1:0] Addr;
  logic              StackFull, StackEmpty, Fault;
  logic [DW-1:0]     Depth;

  int checks   = 0;
  int failures = 0;

  int m_addr;
  int m_stack[$];
  bit m_fault;

  pc_ctrl #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_D(STACK_D)) dut (
    .Clk(Clk), .Clr(Clr), .Up(Up), .Branch(Branch), .Offset(Offset),
    .Jump(Jump), .Call(Call), .Ret(Ret), .Target(Target), .Addr(Addr),
    .StackFull(StackFull), .StackEmpty(StackEmpty), .Depth(Depth),
    .Fault(Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  32'(Addr),       m_addr);
    check({tag, ".depth"}, 32'(Depth),      m_stack.size());
    check({tag, ".full"},  32'(StackFull),  32'(m_stack.size() == STACK_D));
    check({tag, ".empty"}, 32'(StackEmpty), 32'(m_stack.size() == 0));
    check({tag, ".fault"}, 32'(Fault),      32'(m_fault));
  endtask

  function automatic int succ(input int a);
`ifdef PC_SATURATE_EN
    return (a == A - 1) ? a : a + 1;
`else
    return (a + 1) % A;
`endif
  endfunction

  task automatic model_reset();
    m_addr = 0;
    m_stack.delete();
    m_fault = 1'b0;
  endtask

  task automatic model_step(input bit up, input bit br, input bit jp,
                            input bit cl, input bit rt,
                            input logic [OFF_W-1:0] off, input int tgt);
    int so;
    so = off[OFF_W-1] ? int'(off) - (1 << OFF_W) : int'(off);
    if (rt) begin
      if (m_stack.size() == 0) m_fault = 1'b1;
      else m_addr = m_stack.pop_back();
    end else if (cl) begin
      if (m_stack.size() == STACK_D) m_fault = 1'b1;
      else begin
        m_stack.push_back(succ(m_addr));
        m_addr = tgt;
      end
    end else if (jp) m_addr = tgt;
    else if (br)     m_addr = ((m_addr + so) % A + A) % A;
    else if (up)     m_addr = succ(m_addr);
  endtask

  // Apply one request set for exactly one rising edge, then compare.
  task automatic do_cycle(input bit up, input bit br, input bit jp,
                          input bit cl, input bit rt,
                          input logic [OFF_W-1:0] off, input int tgt,
                          input string tag);
    Up = up; Branch = br; Jump = jp; Call = cl; Ret = rt;
    Offset = off; Target = tgt[ADDR_W-1:0];
    @(posedge Clk);
    #1;
    model_step(up, br, jp, cl, rt, off, tgt);
    Up = 0; Branch = 0; Jump = 0; Call = 0; Ret = 0;
    check_all(tag);
  endtask

  // Clr pulse away from the edge, followed by one idle edge.
  task automatic do_clr(input string tag);
    Clr = 1'b1;
    #2;
    model_reset();
    check_all({tag, ".async"});
    Clr = 1'b0;
    @(posedge Clk);
    #1;
    check_all({tag, ".idle"});
  endtask

  initial begin
    Clr = 1'b1; Up = 0; Branch = 0; Jump = 0; Call = 0; Ret = 0;
    Offset = '0; Target = '0;
    model_reset();
    #1;
    check_all("reset");
    #11;
    Clr = 1'b0;
    @(posedge Clk); #1;
    check_all("release");
    for (int i = 1; i <= 3; i++) begin
      do_cycle(1, 0, 0, 0, 0, '0, 0, "step");
      check("step_const", 32'(Addr), i);
    end

    // Clr pulse mid-cycle while Up is requested.
    Up = 1'b1;
    #2;
    Clr = 1'b1;
    #1;
    model_reset();
    check("clr_async_addr", 32'(Addr), 0);
    check_all("clr_async");
    Up = 1'b0;
    #1;
    Clr = 1'b0;
    @(posedge Clk); #1;
    check_all("clr_idle");
    for (int i = 1; i <= 3; i++) do_cycle(1, 0, 0, 0, 0, '0, 0, "clr_step");
    check("clr_step_const", 32'(Addr), 3);

    // Long increment run across the all-ones address.
    do_clr("pre_inc");
    for (int i = 0; i < 130; i++) do_cycle(1, 0, 0, 0, 0, '0, 0, "inc130");
`ifdef PC_SATURATE_EN
    check("inc130_final", 32'(Addr), 127);
`else
    check("inc130_final", 32'(Addr), 2);
`endif

    // Relative branches and priority of Jump over Branch.
    do_cycle(0, 0, 1, 0, 0, '0, 10, "jmp10");
    do_cycle(0, 1, 0, 0, 0, OFF_W'(-3), 0, "br_m3");
    check("br_m3_const", 32'(Addr), 7);
    do_cycle(0, 0, 1, 0, 0, '0, 2, "jmp2");
    do_cycle(0, 1, 0, 0, 0, OFF_W'(-5), 0, "br_wrap");
    check("br_wrap_const", 32'(Addr), 125);
    do_cycle(0, 1, 1, 0, 0, OFF_W'(3), 40, "br_jmp");
    check("br_jmp_const", 32'(Addr), 40);

    // Call / Up / Ret round trip.
    do_cycle(0, 0, 1, 0, 0, '0, 5, "jmp5");
    do_cycle(0, 0, 0, 1, 0, '0, 50, "call50");
    check("call50_const", 32'(Addr), 50);
    check("call50_depth", 32'(Depth), 1);
    do_cycle(1, 0, 0, 0, 0, '0, 0, "up1");
    do_cycle(1, 0, 0, 0, 0, '0, 0, "up2");
    check("up2_const", 32'(Addr), 52);
    do_cycle(0, 0, 0, 0, 1, '0, 0, "ret6");
    check("ret6_const", 32'(Addr), 6);
    check("ret6_empty", 32'(StackEmpty), 1);

    // Fill, overflow, then unwind.
    do_clr("pre_fill");
    for (int i = 0; i < STACK_D; i++)
      do_cycle(0, 0, 0, 1, 0, '0, 20 + 10 * i, "fill");
    check("fill_full", 32'(StackFull), 1);
    do_cycle(0, 0, 0, 1, 0, '0, 99, "overflow");
    check("overflow_addr", 32'(Addr), 50);
    check("overflow_fault", 32'(Fault), 1);
    do_cycle(0, 0, 0, 0, 1, '0, 0, "unwind"); check("unwind0", 32'(Addr), 41);
    do_cycle(0, 0, 0, 0, 1, '0, 0, "unwind"); check("unwind1", 32'(Addr), 31);
    do_cycle(0, 0, 0, 0, 1, '0, 0, "unwind"); check("unwind2", 32'(Addr), 21);
    do_cycle(0, 0, 0, 0, 1, '0, 0, "unwind"); check("unwind3", 32'(Addr), 1);
    check("unwind_fault", 32'(Fault), 1);

    // Ret beats Call on an empty stack; Clr clears the fault.
    do_clr("pre_underflow");
    do_cycle(0, 0, 0, 0, 0, '0, 0, "idle");
    do_cycle(0, 0, 0, 1, 1, '0, 77, "ret_call");
    check("ret_call_fault", 32'(Fault), 1);
    check("ret_call_addr", 32'(Addr), 0);
    check("ret_call_depth", 32'(Depth), 0);
    do_clr("post_underflow");
    check("clr_fault", 32'(Fault), 0);

    // Clr with pending returns discards them.
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 1, 0, '0, 60 + i, "pend");
    check("pend_depth", 32'(Depth), 3);
    do_clr("pend_clr");
    do_cycle(0, 0, 0, 0, 1, '0, 0, "pend_ret");
    check("pend_ret_fault", 32'(Fault), 1);

    // Random requests against the reference model.
    do_clr("pre_rand");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) do_clr("rand_clr");
      else
        do_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 15,
                 OFF_W'($urandom_range(0, (1 << OFF_W) - 1)),
                 int'($urandom_range(0, A - 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter controller for instruction-memory addressing; successor to the 7-bit increment-only counter. Adds configurable width, absolute jump, signed relative branch, and call/return through an internal return-address stack with sticky fault reporting. Sits between the instruction decoder/control FSM and the instruction-memory address input.

## Interface
- ADDR_W, 7: address width in bits.
- OFF_W, 5: signed branch-offset width; OFF_W <= ADDR_W.
- STACK_D, 4: return-stack depth in entries; must be >= 2.

- Clk  in  1  clock, rising edge.
- Clr  in  1  reset, asynchronous, active-high.
- Up  in  1  advance to next instruction.
- Branch  in  1  relative branch: Addr + Offset.
- Offset  in  OFF_W  signed two's-complement branch offset.
- Jump  in  1  absolute jump to Target.
- Call  in  1  push Addr+1, go to Target.
- Ret  in  1  pop return address into Addr.
- Target  in  ADDR_W  jump/call destination.
- Addr  out  ADDR_W  current instruction address.
- StackFull  out  1  stack holds STACK_D entries.
- StackEmpty  out  1  stack holds 0 entries.
- Depth  out  $clog2(STACK_D+1)  current stack occupancy.
- Fault  out  1  sticky: overflowing Call or underflowing Ret occurred.

## Operation
- One operation per cycle. Fixed priority: Ret > Call > Jump > Branch > Up > hold. Lower-priority requests in the same cycle are ignored.
- Hold (no request): Addr unchanged.
- Up: Addr <= Addr + 1. Behaviour at all-ones is set by Configuration.
- Branch: Addr <= Addr + sign_extend(Offset), computed modulo 2^ADDR_W (always wraps, in both configurations).
- Jump: Addr <= Target.
- Call, stack not full: push (Addr + 1) mod 2^ADDR_W; Addr <= Target; Depth + 1.
- Call, stack full: no push, Addr unchanged, Fault <= 1.
- Ret, stack not empty: Addr <= top entry; pop; Depth - 1.
- Ret, stack empty: Addr unchanged, Fault <= 1.
- Fault is cleared only by Clr.
- StackFull = (Depth == STACK_D). StackEmpty = (Depth == 0). Both decode combinationally from the registered Depth.
- Stack entry contents are not reset. Only the pointer/Depth resets.

## Timing
- Clr asserted: immediately, and independent of Clk, Addr = 0, Depth = 0, StackEmpty = 1, StackFull = 0, Fault = 0. Clr wins over every request.
- Clr deassertion synchronised by the integrator. Block requires request inputs low during the first edge after release.
- Every operation has 1-cycle latency. Inputs are sampled at the rising edge, and Addr/Depth/Fault show the result after that edge.
- Back-to-back Call/Ret on consecutive cycles is legal. A Ret in the cycle after a Call returns Addr_at_call + 1.
- Clr mid-sequence (e.g. Depth = 3) discards all pending returns. The next Ret faults.

## Configuration
- PC_SATURATE_EN defined: Up with Addr = 2^ADDR_W - 1 holds Addr (the last instruction repeats). A Call at the all-ones address pushes the all-ones address instead of 0.
- PC_SATURATE_EN undefined: Up wraps the all-ones address to 0. The Call push value wraps likewise.
- Branch, Jump and Ret are unaffected in both cases.

## Structure
- Shared package pc_pkg:
  - enum pc_op_e: OP_HOLD, OP_INC, OP_BRANCH, OP_JUMP, OP_CALL, OP_RET.
  - function pc_decode: maps the request inputs to pc_op_e using the fixed priority.
  - default parameter constants.
- Sub-module ret_stack: parametrised LIFO (ADDR_W x STACK_D).
  - Inputs: push, pop, din. Outputs: top, full, empty, depth.
  - Asynchronous pointer reset.
  - Refuses push-when-full and pop-when-empty internally.
- pc_ctrl: holds the Addr register, next-address mux, saturation logic, and Fault register.

## Test plan
- Clr pulse mid-cycle with Up = 1 -> Addr = 0 immediately, without waiting for an edge. After release, Addr steps 0, 1, 2, ... per cycle.
- ADDR_W = 7, Up held from 0 for 130 cycles -> with PC_SATURATE_EN, Addr sticks at 127; without it, Addr reaches 127 then 0, 1, 2.
- Addr = 10, Branch with Offset = -3 -> 7. Addr = 2, Offset = -5 -> 125 (wrap). Branch + Jump (Target = 40) in the same cycle -> 40.
- Addr = 5, Call with Target = 50 -> Addr = 50, Depth = 1. Then Up x2 -> 52. Then Ret -> 6, Depth = 0, StackEmpty = 1.
- STACK_D = 4: 4 Calls -> StackFull = 1. A 5th Call with Target = 99 -> Addr unchanged, Fault = 1. Then 4 Rets unwind correctly and Fault stays 1.
- Empty stack, Ret + Call in the same cycle -> Ret wins: Fault = 1, Addr unchanged, Depth = 0. Clr afterwards -> Fault = 0.
